// File: rtl/seq_slice_adder.sv
// Multi-cycle WIDTH-bit add/subtract, SLICE bits per cycle, low slice first; result N edges after accept.
// Valid/ready on both sides; one operation in flight, input stalls (in_ready=0) until the result is taken.
module seq_slice_adder #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int N   = WIDTH / SLICE;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   localparam int MSB = WIDTH - 1;

   generate
      if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
         $error("seq_slice_adder: WIDTH must be >= 1 and a multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [SLICE-1:0] a_sl, b_sl;
   logic [SLICE:0]   sum_sl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      a_sl    = '0;
      b_sl    = '0;
      sum_sl  = '0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtract is a + ~b + ~borrow, so the datapath only ever adds.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? ~ci : ci;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < N; k++) begin
               if (cnt_q == CW'(k)) begin
                  a_sl = a_q[k*SLICE +: SLICE];
                  b_sl = b_q[k*SLICE +: SLICE];
               end
            end
            sum_sl = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
            for (int k = 0; k < N; k++) begin
               if (cnt_q == CW'(k)) begin
                  s_d[k*SLICE +: SLICE] = sum_sl[SLICE-1:0];
               end
            end
            carry_d = sum_sl[SLICE];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(N-1)) begin
               co_d    = sum_sl[SLICE];
               ovf_d   = (a_q[MSB] == b_q[MSB]) && (s_d[MSB] != a_q[MSB]);
               zero_d  = (s_d == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign s         = s_q;
   assign co        = co_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_seq_slice_adder.sv
// Scoreboard bench for seq_slice_adder: a 32/4 instance under random and directed traffic,
// plus an 8/8 instance for the single-slice corner.
module tb_seq_slice_adder;

   localparam int N32 = 8;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ovf;
      logic        zero;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, ci = 1'b0, sub = 1'b0;
   logic [31:0] a = '0, b = '0, s;
   logic        out_valid, out_ready = 1'b1, co, ovf, zero;

   logic        in_valid8 = 1'b0, in_ready8, ci8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, s8;
   logic        out_valid8, out_ready8 = 1'b1, co8, ovf8, zero8;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_hs = 0;
   int last_acc = 0;
   int rdy_mode = 0;   // 0: ready, 1: stalled, 2: random
   exp_t exp_q[$];

   logic        seen_rise = 1'b0;
   logic        have_snap = 1'b0;
   logic [34:0] snap;

   seq_slice_adder #(.WIDTH(32), .SLICE(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ovf(ovf), .zero(zero)
   );

   seq_slice_adder #(.WIDTH(8), .SLICE(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .ci(ci8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
      .s(s8), .co(co8), .ovf(ovf8), .zero(zero8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit values.
   function automatic exp_t model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mci, input logic msub);
      exp_t e;
      longint unsigned ua, ub, mask, full, uc;
      longint sa, sb, r, lim;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, ma} & mask;
      ub   = {32'd0, mb} & mask;
      uc   = {63'd0, mci};
      if (msub) begin
         full = ua - ub - uc;
         e.co = (ua >= ub + uc);
      end else begin
         full = ua + ub + uc;
         e.co = ((full >> w) & 64'd1) != 0;
      end
      e.s  = 32'(full & mask);
      lim  = longint'(64'd1 << (w - 1));
      sa   = ua[w-1] ? longint'(ua) - 2 * lim : longint'(ua);
      sb   = ub[w-1] ? longint'(ub) - 2 * lim : longint'(ub);
      r    = msub ? sa - sb - longint'(uc) : sa + sb + longint'(uc);
      e.ovf  = (r >= lim) || (r < -lim);
      e.zero = (e.s == 32'd0);
      e.acc  = 0;
      return e;
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tci, input logic tsub);
      exp_t e;
      int   budget;
      logic ok;
      @(posedge clk); #1;
      a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
      budget = 0;
      ok = 1'b0;
      while (!ok && budget < 300) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         budget++;
      end
      if (!ok) begin
         chk("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
      end else begin
         e = model(32, ta, tb, tci, tsub);
         e.acc = cyc + 1;
         exp_q.push_back(e);
         @(posedge clk); #1;
         last_acc = e.acc;
         in_valid = 1'b0;
         a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
      end
   endtask

   task automatic drain();
      int budget = 0;
      while ((exp_q.size() != 0 || !in_ready) && budget < 500) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: compares every presented result with the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         seen_rise = 1'b0;
         have_snap = 1'b0;
      end else if (out_valid) begin
         chk("in_ready_low_while_done", 64'(in_ready), 64'd0);
         if (!seen_rise) begin
            seen_rise = 1'b1;
            if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
            else chk("latency", 64'(cyc - exp_q[0].acc), 64'(N32));
         end
         if (have_snap) chk("hold_stable", {29'd0, s, co, ovf, zero}, {29'd0, snap});
         if (out_ready) begin
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("s", 64'(s), 64'(e.s));
               chk("co", 64'(co), 64'(e.co));
               chk("ovf", 64'(ovf), 64'(e.ovf));
               chk("zero", 64'(zero), 64'(e.zero));
            end
            seen_rise = 1'b0;
            have_snap = 1'b0;
            last_hs   = cyc + 1;
         end else begin
            snap      = {s, co, ovf, zero};
            have_snap = 1'b1;
         end
      end
   end

   initial begin
      exp_t e8;
      int   budget;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_s", 64'(s), 64'd0);
      chk("rst_flags", {61'd0, co, ovf, zero}, 64'd0);
      chk("rst8_state", {60'd0, in_ready8, out_valid8, co8, ovf8}, 64'h8);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed corner cases through the scoreboard.
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      send(32'd5, 32'd7, 1'b0, 1'b1);
      send(32'd5, 32'd7, 1'b1, 1'b1);
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
      drain();

      // Backpressure: result held while a new operand waits at the input.
      rdy_mode = 1;
      send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
      fork
         send(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b1);
         begin
            budget = 0;
            while (!out_valid && budget < 100) begin
               @(posedge clk);
               budget++;
            end
            chk("bp_result_seen", 64'(out_valid), 64'd1);
            repeat (5) @(posedge clk);
            #1;
            rdy_mode = 0;
         end
      join
      chk("bp_turnaround", 64'(last_acc - last_hs), 64'd1);
      drain();

      // Reset in the middle of RUN, after the third slice.
      send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
      chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
      chk("midrun_rst_s", 64'(s), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      send(32'd3, 32'd4, 1'b0, 1'b0);
      drain();

      // Random traffic with random consumer stalls.
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         send(rnd_val(), rnd_val(), 1'($urandom), 1'($urandom));
      end
      rdy_mode = 0;
      drain();

      // Single-slice instance: result one edge after accept.
      @(posedge clk); #1;
      a8 = 8'h80; b8 = 8'h80; ci8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      chk("w8_in_ready", 64'(in_ready8), 64'd1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      a8 = 8'h00; b8 = 8'h00;
      chk("w8_not_yet_valid", 64'(out_valid8), 64'd0);
      @(posedge clk); #1;
      e8 = model(8, 32'h80, 32'h80, 1'b1, 1'b0);
      chk("w8_out_valid", 64'(out_valid8), 64'd1);
      chk("w8_s", 64'(s8), 64'(e8.s));
      chk("w8_co", 64'(co8), 64'(e8.co));
      chk("w8_ovf", 64'(ovf8), 64'(e8.ovf));
      chk("w8_zero", 64'(zero8), 64'(e8.zero));
      @(posedge clk); #1;
      chk("w8_released", {62'd0, out_valid8, in_ready8}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_slice_adder.md
# seq_slice_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation SLICE bits per clock, low slice first, carrying between slices in a register. It replaces the fixed 4-bit ripple chain wherever a wide add/subtract is needed but a full-width carry path does not fit the cycle. Operands enter and results leave over valid/ready handshakes. Status flags are produced alongside the sum.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 1.
- SLICE, 4, bits added per RUN cycle. WIDTH % SLICE ≠ 0 is an elaboration error. N = WIDTH/SLICE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; equals (state == IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in for add, borrow-in for subtract.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result registers hold a finished result.
- out_ready  in  1  consumer takes result.
- s  out  WIDTH  sum/difference.
- co  out  1  raw carry out of MSB (in subtract: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b_eff = sub ? ~b : b, and carry = sub ? ~ci : ci. Clear slice counter. Go to RUN.
- RUN: each cycle add slice k of a, slice k of b_eff, and carry. Write the SLICE-bit result into s[k*SLICE +: SLICE]. Store the slice carry-out in carry and increment k. After slice N-1, go to DONE.
- DONE entry: co = final carry. ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]). zero = (s == 0). out_valid=1.
- DONE: hold s/co/ovf/zero/out_valid stable while out_ready=0. On out_valid&&out_ready go to IDLE; out_valid drops on that edge.
- Arithmetic: add gives s = (a + b + ci) mod 2^WIDTH. Subtract gives s = (a − b − ci) mod 2^WIDTH. co is the (WIDTH+1)th bit of a + b_eff + carry_in_eff.
- s, co, ovf and zero are meaningful only while out_valid=1. s changes slice by slice during RUN. co, ovf and zero keep their last values until the next DONE entry.
- in_valid is ignored outside IDLE. The consumer must not rely on combinational in-to-out paths; there are none.
- The slice counter is $clog2(N) bits wide, with a minimum of 1.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, s=0, co=0, ovf=0, zero=0, counter=0, carry=0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately; no result is produced. Operation resumes cleanly on the first edge after release.
- Latency: handshake at edge E0; slices computed at edges E1..EN; out_valid=1 from EN until the output handshake.
- With SLICE=WIDTH (N=1), out_valid rises one edge after acceptance.
- Throughput: at best one operation per N+2 cycles. in_ready rises one cycle after the output handshake; there is no same-cycle turnaround.
- Inputs a, b, ci and sub are sampled only at the accept edge. Changes afterwards have no effect.

## Test plan
- WIDTH=32, SLICE=4, add, a=0xFFFFFFFF, b=0x1, ci=0, out_ready=1 -> s=0x00000000, co=1, ovf=0, zero=1; out_valid exactly 8 edges after accept.
- Subtract, a=5, b=7, ci=0 -> s=0xFFFFFFFE, co=0, ovf=0, zero=0. Repeat with ci=1 -> s=0xFFFFFFFD.
- Add a=0x7FFFFFFF, b=0x1, ci=0 -> s=0x80000000, ovf=1, co=0. Subtract a=0x80000000, b=0x1 -> s=0x7FFFFFFF, ovf=1, co=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> in_ready=0 throughout and outputs stable. The second operation is accepted one cycle after the out handshake and its result is correct.
- Assert rst_n=0 during RUN after slice 3 -> out_valid=0 and in_ready=1 immediately; s=0. The next operation after release (a=3, b=4, add) gives s=7.
- WIDTH=8, SLICE=8 instance, add a=0x80, b=0x80, ci=1 -> s=0x01, co=1, ovf=1; out_valid one edge after accept.
